// File: rtl/keccak_pad_absorb.sv
// keccak_pad_absorb: packs a byte stream into rate-sized sponge blocks with suffix and pad10*1 padding
// clk/reset           : rising-edge clock, synchronous active-high reset
// mode                : 0 = SHAKE (suffix 0x1F), 1 = cSHAKE (suffix 0x04), latched on first beat
// in_valid/in_ready   : byte-beat handshake; in_data byte, in_keep byte present, in_last end of message
// blk_valid/blk_ready : block handshake; blk_data byte i at [8i+7:8i]
// blk_last/blk_count  : final padded block flag, saturating blocks-emitted count in this message
module keccak_pad_absorb #(
   parameter int RATE_BYTES = 136,
   parameter int CNT_W      = 8,
   parameter int BLK_CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_data,
   input  logic                    in_keep,
   input  logic                    in_last,
   output logic                    blk_valid,
   input  logic                    blk_ready,
   output logic [8*RATE_BYTES-1:0] blk_data,
   output logic                    blk_last,
   output logic [BLK_CNT_W-1:0]    blk_count
);
   localparam logic [1:0] FILL = 2'd0, EMIT = 2'd1, PADBLK = 2'd2;
   localparam logic [CNT_W-1:0] R_FULL = CNT_W'(RATE_BYTES);
   logic [1:0] state, state_n;
   logic [8*RATE_BYTES-1:0] data_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_after;
   logic [BLK_CNT_W-1:0] count_n, count_inc;
   logic mode_q, mode_n, busy, busy_n, pad_pending, pad_n, last_n;
   logic accept, m, done;
   logic [7:0] suffix;
   assign accept    = in_valid & in_ready & (in_keep | in_last);
   // busy marks a message in progress, so the live mode input only matters on its first beat
   assign m         = busy ? mode_q : mode;
   assign suffix    = m ? 8'h04 : 8'h1F;
   assign cnt_after = cnt + CNT_W'(in_keep);
   // last beat leaves room in this block for the padding
   assign done      = in_last && cnt_after != R_FULL;
   assign count_inc = &blk_count ? blk_count : blk_count + BLK_CNT_W'(1);
   always_comb begin
      state_n = state;
      data_n  = blk_data;
      cnt_n   = cnt;
      mode_n  = mode_q;
      busy_n  = busy;
      pad_n   = pad_pending;
      last_n  = blk_last;
      count_n = blk_count;
      if (state == FILL) begin
         if (accept) begin
            // unwritten bytes are zero, so xor-ing suffix and 0x80 onto one byte yields suffix|0x80
            for (int i = 0; i < RATE_BYTES; i++) begin
               if (in_keep && CNT_W'(i) == cnt) data_n[8*i +: 8] = in_data;
               if (done && CNT_W'(i) == cnt_after) data_n[8*i +: 8] = data_n[8*i +: 8] ^ suffix;
            end
            if (done) data_n[8*RATE_BYTES-8 +: 8] = data_n[8*RATE_BYTES-8 +: 8] ^ 8'h80;
            cnt_n  = cnt_after;
            mode_n = m;
            busy_n = !in_last;
            if (in_last || cnt_after == R_FULL) begin
               state_n = EMIT;
               last_n  = done;
               pad_n   = in_last && !done;
               count_n = count_inc;
            end
         end
      end else if (state == EMIT) begin
         if (blk_ready) begin
            data_n  = '0;
            cnt_n   = '0;
            last_n  = 1'b0;
            state_n = pad_pending ? PADBLK : FILL;
            if (blk_last) count_n = '0;
         end
      end else begin
         data_n                       = '0;
         data_n[7:0]                  = mode_q ? 8'h04 : 8'h1F;
         data_n[8*RATE_BYTES-8 +: 8]  = 8'h80;
         state_n                      = EMIT;
         pad_n                        = 1'b0;
         last_n                       = 1'b1;
         count_n                      = count_inc;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FILL;
         blk_data    <= '0;
         cnt         <= '0;
         mode_q      <= 1'b0;
         busy        <= 1'b0;
         pad_pending <= 1'b0;
         blk_last    <= 1'b0;
         blk_count   <= '0;
         in_ready    <= 1'b0;
         blk_valid   <= 1'b0;
      end else begin
         state       <= state_n;
         blk_data    <= data_n;
         cnt         <= cnt_n;
         mode_q      <= mode_n;
         busy        <= busy_n;
         pad_pending <= pad_n;
         blk_last    <= last_n;
         blk_count   <= count_n;
         in_ready    <= state_n == FILL;
         blk_valid   <= state_n == EMIT;
      end
   end
endmodule

// File: tb/tb_keccak_pad_absorb.sv
// tb_keccak_pad_absorb: scoreboard bench for the sponge padding front end at rates 136 and 168
module tb_keccak_pad_absorb;
   typedef struct packed {
      logic [1343:0] d;
      logic          l;
      logic [15:0]   c;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b1, mode = 1'b0, in_valid = 1'b0, in_keep = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic in_ready, blk_valid, blk_last;
   logic [1087:0] blk_data;
   logic [15:0] blk_count;
   logic m2 = 1'b0, iv2 = 1'b0, ik2 = 1'b0, il2 = 1'b0, br2 = 1'b1;
   logic [7:0] id2 = 8'h00;
   logic ir2, bv2, bl2;
   logic [1343:0] bd2;
   logic [15:0] bc2;
   exp_t q1[$], q2[$];
   int vecs = 0, errs = 0, hold = 0, stall = 0;
   logic [1087:0] held;
   keccak_pad_absorb dut (
      .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .blk_valid(blk_valid),
      .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last), .blk_count(blk_count)
   );
   keccak_pad_absorb #(.RATE_BYTES(168)) dut168 (
      .clk(clk), .reset(reset), .mode(m2), .in_valid(iv2), .in_ready(ir2),
      .in_data(id2), .in_keep(ik2), .in_last(il2), .blk_valid(bv2),
      .blk_ready(br2), .blk_data(bd2), .blk_last(bl2), .blk_count(bc2)
   );
   task automatic chk(input string name, input logic [1343:0] act, input logic [1343:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic send(input logic [7:0] d, input logic k, input logic l, input logic s);
      int n = 0;
      if (s) begin iv2 = 1'b1; id2 = d; ik2 = k; il2 = l; end
      else begin in_valid = 1'b1; in_data = d; in_keep = k; in_last = l; end
      @(negedge clk);
      while (!(s ? ir2 : in_ready) && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         vecs++; errs++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0; iv2 = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while ((q1.size() != 0 || q2.size() != 0 || blk_valid || bv2) && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin
         vecs++; errs++;
         $display("FAIL drain_timeout: %0d and %0d blocks outstanding, required 0", q1.size(), q2.size());
      end
      @(posedge clk); #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         blk_ready = 1'b0; hold = 0;
      end else if (blk_valid && !blk_ready) begin
         if (q1.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_block: blk_valid 1 with no block expected, count %0d", blk_count);
            blk_ready = 1'b1;
         end else if (hold < stall) begin
            if (hold > 0) begin
               chk("stall_data_stable", 1344'(blk_data), 1344'(held));
               chk("stall_in_ready", 1344'(in_ready), '0);
            end
            held = blk_data;
            hold++;
         end else begin
            e = q1.pop_front();
            chk("blk_data", 1344'(blk_data), e.d);
            chk("blk_last", 1344'(blk_last), 1344'(e.l));
            chk("blk_count", 1344'(blk_count), 1344'(e.c));
            blk_ready = 1'b1; hold = 0;
         end
      end else blk_ready = 1'b0;
   end
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bv2) begin
         if (q2.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_block168: blk_valid 1 with no block expected");
         end else begin
            e = q2.pop_front();
            chk("blk_data168", bd2, e.d);
            chk("blk_last168", 1344'(bl2), 1344'(e.l));
            chk("blk_count168", 1344'(bc2), 1344'(e.c));
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end
   initial begin
      exp_t e;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 1344'(in_ready), '0);
      chk("rst_blk_valid", 1344'(blk_valid), '0);
      chk("rst_blk_data", 1344'(blk_data), '0);
      chk("rst_blk_last", 1344'(blk_last), '0);
      chk("rst_blk_count", 1344'(blk_count), '0);
      chk("rst_in_ready168", 1344'(ir2), '0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_reset", 1344'(in_ready), 1344'(1));
      // empty SHAKE message
      mode = 1'b0;
      e = '0; e.d[7:0] = 8'h1F; e.d[8*135 +: 8] = 8'h80; e.l = 1'b1; e.c = 16'd1;
      q1.push_back(e);
      send(8'h00, 1'b0, 1'b1, 1'b0);
      drain();
      // cSHAKE, 135 bytes: suffix and final pad share byte 135
      mode = 1'b1;
      e = '0;
      for (int i = 0; i < 135; i++) e.d[8*i +: 8] = 8'(i);
      e.d[8*135 +: 8] = 8'h84; e.l = 1'b1; e.c = 16'd1;
      q1.push_back(e);
      for (int i = 0; i < 135; i++) send(8'(i), 1'b1, i == 134, 1'b0);
      chk("latency_blk_valid", 1344'(blk_valid), 1344'(1));
      drain();
      // exactly one full rate of data, without then with backpressure
      mode = 1'b0;
      for (int r = 0; r < 2; r++) begin
         stall = r * 10;
         e = '0;
         for (int i = 0; i < 136; i++) e.d[8*i +: 8] = 8'hA5;
         e.l = 1'b0; e.c = 16'd1;
         q1.push_back(e);
         e = '0; e.d[7:0] = 8'h1F; e.d[8*135 +: 8] = 8'h80; e.l = 1'b1; e.c = 16'd2;
         q1.push_back(e);
         for (int i = 0; i < 136; i++) send(8'hA5, 1'b1, i == 135, 1'b0);
         drain();
      end
      stall = 0;
      // 140-byte cSHAKE message spanning two blocks
      mode = 1'b1;
      e = '0;
      for (int i = 0; i < 136; i++) e.d[8*i +: 8] = 8'h3C;
      e.l = 1'b0; e.c = 16'd1;
      q1.push_back(e);
      e = '0;
      for (int i = 0; i < 4; i++) e.d[8*i +: 8] = 8'h3C;
      e.d[8*4 +: 8] = 8'h04; e.d[8*135 +: 8] = 8'h80; e.l = 1'b1; e.c = 16'd2;
      q1.push_back(e);
      for (int i = 0; i < 140; i++) send(8'h3C, 1'b1, i == 139, 1'b0);
      drain();
      // reset mid-message discards partial data
      mode = 1'b0;
      for (int i = 0; i < 50; i++) send(8'(i + 7), 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_blk_data", 1344'(blk_data), '0);
      chk("midrst_in_ready", 1344'(in_ready), '0);
      reset = 1'b0;
      @(posedge clk); #1;
      // cSHAKE 01 02 03 with mode flipped mid-message and an ignored empty beat
      e = '0;
      e.d[7:0] = 8'h01; e.d[15:8] = 8'h02; e.d[23:16] = 8'h03; e.d[31:24] = 8'h04;
      e.d[8*135 +: 8] = 8'h80; e.l = 1'b1; e.c = 16'd1;
      q1.push_back(e);
      mode = 1'b1;
      send(8'h01, 1'b1, 1'b0, 1'b0);
      mode = 1'b0;
      send(8'hEE, 1'b0, 1'b0, 1'b0);
      send(8'h02, 1'b1, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b1, 1'b0);
      drain();
      // rate 168, 167 bytes: suffix and pad share byte 167
      m2 = 1'b0;
      e = '0;
      for (int i = 0; i < 167; i++) e.d[8*i +: 8] = 8'(i);
      e.d[8*167 +: 8] = 8'h9F; e.l = 1'b1; e.c = 16'd1;
      q2.push_back(e);
      for (int i = 0; i < 167; i++) send(8'(i), 1'b1, i == 166, 1'b1);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/keccak_pad_absorb.md
Name: keccak_pad_absorb

Overview:
- Parametrised sponge front end for the SHAKE/cSHAKE cores.
- Accepts a byte stream with a valid/ready handshake and packs it into rate-sized blocks.
- Applies domain-separation suffix and pad10*1 padding, then hands complete blocks to the permutation controller with a block-level valid/ready handshake.
- Replaces hard-wired 1088-bit, bit-serial padding: rate and mode are selectable, and backpressure is supported.

Parameters:
- RATE_BYTES, 136, sponge rate in bytes (136 = SHAKE256/cSHAKE256, 168 = SHAKE128/cSHAKE128); legal range 2..200.
- CNT_W, 8, width of the internal byte counter; must satisfy 2^CNT_W > RATE_BYTES.
- BLK_CNT_W, 16, width of the per-message block counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = SHAKE (suffix 0x1F), 1 = cSHAKE (suffix 0x04); sampled on the first accepted beat of each message.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  8  message byte.
- in_keep  input  1  1 = in_data carries a byte; 0 = beat carries no byte (legal only with in_last).
- in_last  input  1  final beat of the message.
- blk_valid  output  1  blk_data holds a complete block.
- blk_ready  input  1  consumer accepts the block.
- blk_data  output  8*RATE_BYTES  block; byte i at bits [8i+7:8i].
- blk_last  output  1  block is the final (padded) block of the message.
- blk_count  output  BLK_CNT_W  blocks emitted in the current message, including the one on blk_data; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: in_ready=0, blk_valid=0, blk_last=0, blk_data=0, blk_count=0.
  - State goes to FILL; byte counter cleared; latched mode cleared.
  - in_ready rises the cycle after reset deasserts.
  - Reset mid-message or while blk_valid is high discards all partial data. No block is emitted.
- States: FILL, EMIT, PADBLK.
- FILL:
  - in_ready=1; a beat is accepted when in_valid & in_ready.
  - in_keep=1: byte written at index cnt, then cnt increments.
  - cnt reaches RATE_BYTES without in_last: go to EMIT with blk_last=0.
  - in_last with cnt_after < RATE_BYTES: padding is applied in the same cycle:
    - byte[cnt_after] ^= suffix;
    - byte[RATE_BYTES-1] ^= 0x80;
    - if both land on the same byte, the result is suffix|0x80 (0x9F SHAKE, 0x84 cSHAKE).
    - Then go to EMIT with blk_last=1.
  - in_last with cnt_after == RATE_BYTES: go to EMIT with blk_last=0 and set pad_pending.
  - Unwritten bytes are always 0.
- EMIT:
  - in_ready=0; blk_valid=1 from the cycle after the completing beat. Latency is 1 cycle from the accepted beat to blk_valid.
  - blk_data, blk_last and blk_count stay stable while blk_valid & !blk_ready.
  - On blk_valid & blk_ready:
    - buffer and cnt are cleared;
    - if pad_pending: go to PADBLK;
    - else if blk_last: blk_count resets to 0 and state returns to FILL;
    - else: return to FILL.
- PADBLK:
  - One cycle to build the padding-only block: byte0 = suffix, byte[RATE_BYTES-1] = 0x80, all others 0.
  - Then EMIT with blk_last=1; pad_pending cleared.
- blk_count: increments when a block enters EMIT; cleared on the handshake of the last block.
- Mode latching: mode is latched on the first accepted beat of a message. Changes to mode mid-message are ignored.
- in_valid with in_keep=0 and in_last=0 is illegal. The beat is accepted and ignored.
- Empty message: a single beat with in_keep=0, in_last=1 at cnt=0 produces one pad-only block.
- Back-to-back messages: a new message is accepted in FILL on the cycle after the last-block handshake. There is no bubble beyond that.

Test Plan:
- RATE_BYTES=136, mode=0, single beat keep=0,last=1 -> one block: byte0=0x1F, byte135=0x80, rest 0, blk_last=1, blk_count=1.
- RATE_BYTES=136, mode=1, 135 bytes 0x00..0x86 with last on byte 134 -> byte135=0x84, blk_last=1, blk_valid asserted 1 cycle after last beat.
- RATE_BYTES=136, mode=0, 136 bytes of 0xA5 -> block 1 all 0xA5, blk_last=0, blk_count=1; block 2: byte0=0x1F, byte135=0x80, blk_last=1, blk_count=2.
- blk_ready held 0 for 10 cycles on each block -> blk_data stable, in_ready=0 throughout, no bytes lost; digest blocks match the no-stall run.
- Assert reset after 50 of 100 bytes, then send a 3-byte cSHAKE message 0x01,0x02,0x03 -> no block before reset; then one block 01 02 03 04 00.. 80, blk_last=1.
- RATE_BYTES=168, mode=0, 167 bytes -> byte167=0x9F, single block, blk_last=1.
